mux2_arbiter: RTL and testbench
===============================

# mux2_arbiter

Round-robin arbiter that shares one WIDTH-bit datapath between two valid/ready requesters (A and B). It selects the winner through a `mux2_1` instance and registers the selected word into a single-entry output stage. It sits in front of a shared resource such as a unified memory port, with fetch on A and load/store on B. It guarantees no data loss, no duplication and alternation under contention.

## Interface
- `WIDTH`, 64, data width of both inputs and the output.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a_valid`  in  1  requester A presents `a_data`.
- `a_ready`  out  1  A's word is accepted this cycle (handshake when `a_valid && a_ready`).
- `a_data`  in  WIDTH  requester A payload.
- `b_valid`  in  1  requester B presents `b_data`.
- `b_ready`  out  1  B's word is accepted this cycle.
- `b_data`  in  WIDTH  requester B payload.
- `out_valid`  out  1  output register holds a word.
- `out_ready`  in  1  downstream consumes the output word this cycle.
- `out_data`  out  WIDTH  registered winning payload.
- `out_src`  out  1  origin of `out_data`: 0 = A, 1 = B.

## Operation
- State: `prio` (1 bit, 0 = A favoured, 1 = B favoured) and the output stage (`out_valid`, `out_data`, `out_src`).
- Output stage FSM:
  - EMPTY (`out_valid`=0): moves to FULL on any input handshake.
  - FULL (`out_valid`=1): on `out_ready`, moves to EMPTY if no input handshake that cycle. Stays FULL (reloaded) if there is one.
- `space = !out_valid || out_ready`: the stage can take a word this cycle.
- Grant (combinational):
  - Only A valid: grant = A.
  - Only B valid: grant = B.
  - Both valid: grant = `prio`.
  - Neither valid: no grant.
- `a_ready = rst_n && space && grant==A`; `b_ready = rst_n && space && grant==B`. At most one ready is high per cycle.
- `a_ready` depends combinationally on `b_valid`, and vice versa. Requesters must not make valid depend on ready.
- Data path: `mux2_1` sel = grant (0 = A, 1 = B). Its output is loaded into `out_data` on a handshake, and `out_src` <= grant.
- On a handshake from source s, `prio <= ~s`. Without a handshake, `prio` holds. A lone requester therefore hands priority to the other side after each transfer.
- A requester holding `valid` without receiving `ready` must keep its data stable. The arbiter never drops or reorders words from one source.

## Timing
- Reset (async assert, sync-release safe): `out_valid`=0, `out_data`=0, `out_src`=0, `prio`=0. `a_ready`=`b_ready`=0 while `rst_n` is low.
- Latency: an input handshake in cycle N gives `out_valid`=1 with that data in cycle N+1.
- Throughput: one word per cycle while `out_ready`=1. Pass-through with simultaneous drain and load works with no bubble.
- Backpressure: FULL with `out_ready`=0 forces both readies to 0. `out_data`/`out_src` stay stable until consumed.
- Contention: both valid continuously with `out_ready`=1 gives an accepted sequence of A, B, A, B… starting from the current `prio`.
- Reset mid-transfer: a buffered word is discarded, `prio` returns to A, and no ready is asserted until `rst_n` is high.
- Grant is evaluated every cycle; there is no lock beyond the handshake. A requester that drops `valid` before acceptance simply loses its turn, and `prio` is unchanged.

## Structure
- Shared package `arb_pkg`:
  - `typedef enum logic {SRC_A=1'b0, SRC_B=1'b1} src_e`, used for `prio`, grant and `out_src`.
  - Constant `ARB_PRIO_RESET = SRC_A`.
- Sub-module: one `mux2_1 #(WIDTH)` instance (ports `a`, `b`, `sel`, `out`) for the payload select. All control logic stays in `mux2_arbiter`.

## Test plan
- Reset then idle: `rst_n`=0 for 3 cycles with `a_valid`=`b_valid`=1 -> `a_ready`=`b_ready`=0 and `out_valid`=0 throughout. After release, the first grant goes to A.
- Lone A stream: `a_valid`=1 with data 1,2,3, `b_valid`=0, `out_ready`=1 -> `out_data` shows 1,2,3 in consecutive cycles, each one cycle after its handshake, with `out_src`=0.
- Contention: both valid continuously, A data 0x10.., B data 0x20.., `out_ready`=1 -> outputs 0x10, 0x20, 0x11, 0x21… with `out_src` alternating 0,1,0,1.
- Backpressure: after the stage fills with 0xAA, hold `out_ready`=0 for 4 cycles -> `out_data`=0xAA stable and both readies 0. On release, the next word follows with no gap.
- Reset mid-operation: FULL with `out_src`=1, `prio`=0, then assert `rst_n`=0 for 1 cycle -> `out_valid`=0 immediately (asynchronous) and `prio`=A. Both valid after release -> A wins first.
- Priority after a lone transfer: B alone sends 0x5, then A and B both valid -> A wins next (`prio` became A).

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types for the two-requester round-robin arbiter.
// Latency: none, because this file holds only declarations.
// Backpressure: not applicable.
package arb_pkg;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

    typedef enum logic {
        STG_EMPTY = 1'b0,
        STG_FULL  = 1'b1
    } stage_e;

    localparam src_e ARB_PRIO_RESET = SRC_A;

    // After a transfer, priority passes to the side that did not win.
    function automatic src_e other_src(input src_e s);
        return (s == SRC_A) ? SRC_B : SRC_A;
    endfunction

endpackage

// File: rtl/mux2_arbiter_mux2_1.sv
// Two-input WIDTH-bit payload select. sel=0 passes a, sel=1 passes b.
// Latency: combinational.
// Backpressure: none.
module mux2_1 #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);

    assign out = sel ? b : a;

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter that merges requesters A and B into one registered output stage.
// Latency: a word handshaken in cycle N is presented at the output in cycle N+1.
// Backpressure: a full stage with out_ready low holds both readies low.
module mux2_arbiter
    import arb_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src
);

    stage_e           r_state;
    src_e             r_prio;
    src_e             r_out_src;
    logic [WIDTH-1:0] r_out_data;

    logic             w_space;
    logic             w_req;
    src_e             w_grant;
    logic             w_hs;
    logic [WIDTH-1:0] w_mux_out;

    assign w_space = (r_state == STG_EMPTY) || out_ready;
    assign w_req   = a_valid || b_valid;

    always_comb begin
        w_grant = SRC_A;
        if (a_valid && b_valid) begin
            w_grant = r_prio;
        end else if (b_valid) begin
            w_grant = SRC_B;
        end
    end

    // rst_n gates the readies so that no handshake is seen while reset is held.
    assign a_ready = rst_n && w_space && w_req && (w_grant == SRC_A);
    assign b_ready = rst_n && w_space && w_req && (w_grant == SRC_B);
    assign w_hs    = rst_n && w_space && w_req;

    mux2_1 #(
        .WIDTH (WIDTH)
    ) u_mux (
        .a   (a_data),
        .b   (b_data),
        .sel (w_grant == SRC_B),
        .out (w_mux_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= STG_EMPTY;
            r_prio     <= ARB_PRIO_RESET;
            r_out_src  <= SRC_A;
            r_out_data <= '0;
        end else begin
            case (r_state)
                STG_EMPTY: begin
                    if (w_hs) begin
                        r_state <= STG_FULL;
                    end
                end
                STG_FULL: begin
                    if (out_ready && !w_hs) begin
                        r_state <= STG_EMPTY;
                    end
                end
                default: r_state <= STG_EMPTY;
            endcase
            if (w_hs) begin
                r_out_data <= w_mux_out;
                r_out_src  <= w_grant;
                r_prio     <= other_src(w_grant);
            end
        end
    end

    assign out_valid = (r_state == STG_FULL);
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed bench for mux2_arbiter: reset, contention, lone streams, backpressure, mid-run reset.
module tb_mux2_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_valid, a_ready, b_valid, b_ready;
    logic [63:0] a_data, b_data, out_data;
    logic        out_valid, out_ready, out_src;

    int n_cmp = 0;
    int n_err = 0;

    mux2_arbiter #(.WIDTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_data    (b_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [63:0] d, input logic s);
        chk({tag, ".valid"}, {63'd0, out_valid}, {63'd0, v});
        chk({tag, ".data"},  out_data, d);
        chk({tag, ".src"},   {63'd0, out_src}, {63'd0, s});
    endtask

    task automatic chk_rdy(input string tag, input logic ar, input logic br);
        chk({tag, ".a_ready"}, {63'd0, a_ready}, {63'd0, ar});
        chk({tag, ".b_ready"}, {63'd0, b_ready}, {63'd0, br});
    endtask

    initial begin
        // Reset held with both requesters valid.
        rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
        a_data = 64'h10; b_data = 64'h20; out_ready = 1'b1;
        #2;
        chk_out("rst0", 1'b0, 64'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk_rdy("rst_hold", 1'b0, 1'b0);
            chk("rst_hold.valid", {63'd0, out_valid}, 64'd0);
            tick();
        end
        rst_n = 1'b1;
        #1;
        chk_rdy("first_grant", 1'b1, 1'b0);

        // Contention: expect A 0x10, B 0x20, A 0x11, B 0x21.
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i % 2 == 0) a_data = 64'h10 + 64'(i / 2 + 1);
            else            b_data = 64'h20 + 64'(i / 2 + 1);
            #1;
            if (i % 2 == 0) begin
                chk_out("cont", 1'b1, 64'h10 + 64'(i / 2), 1'b0);
                chk_rdy("cont", 1'b0, 1'b1);
            end else begin
                chk_out("cont", 1'b1, 64'h20 + 64'(i / 2), 1'b1);
                chk_rdy("cont", 1'b1, 1'b0);
            end
        end

        // Lone A stream 1,2,3.
        b_valid = 1'b0; a_data = 64'd1;
        #1;
        chk_rdy("loneA0", 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (i < 3) a_data = 64'(i + 1);
            else       a_valid = 1'b0;
            #1;
            chk_out("loneA", 1'b1, 64'(i), 1'b0);
            chk_rdy("loneA", i < 3, 1'b0);
        end
        tick();
        chk("drain.valid", {63'd0, out_valid}, 64'd0);

        // Backpressure: B fills stage with 0xAA (prio is B after lone A).
        b_valid = 1'b1; b_data = 64'hAA;
        #1;
        chk_rdy("bp_load", 1'b0, 1'b1);
        tick();
        out_ready = 1'b0; b_data = 64'hBB; a_valid = 1'b1; a_data = 64'h30;
        #1;
        chk_out("bp_full", 1'b1, 64'hAA, 1'b1);
        chk_rdy("bp_full", 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("bp_hold", 1'b1, 64'hAA, 1'b1);
            chk_rdy("bp_hold", 1'b0, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        chk_rdy("bp_release", 1'b1, 1'b0);
        tick();
        a_valid = 1'b0;
        #1;
        chk_out("bp_next", 1'b1, 64'h30, 1'b0);
        chk_rdy("bp_next", 1'b0, 1'b1);
        tick();
        b_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk_out("pre_rst", 1'b1, 64'hBB, 1'b1);

        // Mid-run reset with the stage full (src=B, prio=A).
        a_valid = 1'b1; b_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_out("mid_rst", 1'b0, 64'h0, 1'b0);
        chk_rdy("mid_rst", 1'b0, 1'b0);
        tick();
        chk_rdy("mid_rst_hold", 1'b0, 1'b0);
        rst_n = 1'b1; out_ready = 1'b1; a_data = 64'h40; b_data = 64'h50;
        #1;
        chk_rdy("post_rst", 1'b1, 1'b0);
        tick();
        a_valid = 1'b0; b_data = 64'h5;
        #1;
        chk_out("post_rst", 1'b1, 64'h40, 1'b0);
        chk_rdy("loneB", 1'b0, 1'b1);

        // B alone sends 0x5, so A must win the next contended cycle.
        tick();
        a_valid = 1'b1; a_data = 64'h41; b_data = 64'h51;
        #1;
        chk_out("loneB", 1'b1, 64'h5, 1'b1);
        chk_rdy("prio_after_B", 1'b1, 1'b0);
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        #1;
        chk_out("prio_after_B", 1'b1, 64'h41, 1'b0);
        tick();
        chk("final.valid", {63'd0, out_valid}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
